matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer_pkg.sv | 36 +++
 rtl/matmul_byte_serializer.sv | 64 ++++++
 rtl/matmul_sequencer.sv | 146 ++++++++++++++
 tb/tb_matmul_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_sequencer_pkg.sv
//============================================================================
// Package : matmul_sequencer_pkg
// Brief   : Shared state encoding, sizes and result-byte helper for the
//           matmul sequencer.
// Rev     : 1.0
//============================================================================
`default_nettype none

package matmul_sequencer_pkg;

    localparam int N_ELEM    = 9;
    localparam int IN_BYTES  = 18;
    localparam int OUT_BYTES = 27;
    localparam int OPW       = 8;
    localparam int ACCW      = 18;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } seq_state_t;

    // Byte sel of an 18-bit result: low byte, middle byte, then the 2 MSBs.
    function automatic logic [OPW-1:0] result_byte(input logic [ACCW-1:0] word,
                                                   input logic [1:0]      sel);
        case (sel)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            default: return {6'b0, word[17:16]};
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_byte_serializer.sv
//============================================================================
// Module : matmul_byte_serializer
// Brief  : Holds the 9x18 result register and streams it as 27 bytes
//          over a valid/ready handshake.
// Rev    : 1.0
//============================================================================
`default_nettype none

module matmul_byte_serializer
    import matmul_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_capture,
    input  logic                   i_drain,
    input  logic [N_ELEM*ACCW-1:0] i_result,
    input  logic                   i_out_ready,
    output logic                   o_out_valid,
    output logic [OPW-1:0]         o_out_data,
    output logic                   o_last_xfer
);

    logic [ACCW-1:0] r_result [N_ELEM];
    logic [3:0]      r_elem;
    logic [1:0]      r_sub;
    logic [4:0]      r_count;
    logic            w_xfer;

    assign w_xfer      = i_drain & i_out_ready;
    assign o_last_xfer = w_xfer && (r_count == 5'(OUT_BYTES - 1));
    assign o_out_valid = i_drain;
    assign o_out_data  = i_drain ? result_byte(r_result[r_elem], r_sub) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ELEM; i++) r_result[i] <= '0;
            r_elem  <= '0;
            r_sub   <= '0;
            r_count <= '0;
        end else if (i_capture) begin
            for (int i = 0; i < N_ELEM; i++) r_result[i] <= i_result[i*ACCW +: ACCW];
            r_elem  <= '0;
            r_sub   <= '0;
            r_count <= '0;
        end else if (w_xfer) begin
            if (o_last_xfer) begin
                r_elem  <= '0;
                r_sub   <= '0;
                r_count <= '0;
            end else begin
                r_count <= r_count + 5'd1;
                if (r_sub == 2'd2) begin
                    r_sub  <= '0;
                    r_elem <= r_elem + 4'd1;
                end else begin
                    r_sub <= r_sub + 2'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/matmul_sequencer.sv
//============================================================================
// Module : matmul_sequencer
// Brief  : Loads 3x3 A/B operand bytes, runs an external matmul engine and
//          streams the 9 results as bytes. Optional RUN timeout with
//          MATMUL_SEQ_TIMEOUT_EN.
// Rev    : 1.0
//============================================================================
`default_nettype none

module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [OPW-1:0]         in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [OPW-1:0]         out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [N_ELEM*OPW-1:0]  mm_a,
    output logic [N_ELEM*OPW-1:0]  mm_b,
    output logic                   mm_enable,
    input  logic [N_ELEM*ACCW-1:0] mm_c,
    input  logic                   mm_done,
    output logic                   error
);

    seq_state_t     r_state;
    seq_state_t     w_next;
    logic [4:0]     r_idx;
    logic [OPW-1:0] r_a [N_ELEM];
    logic [OPW-1:0] r_b [N_ELEM];
    logic           w_in_xfer;
    logic           w_last_in;
    logic           w_capture;
    logic           w_drain;
    logic           w_last_out;
    logic           w_tmo_expired;

    assign w_in_xfer = (r_state == LOAD) && in_valid;
    assign w_last_in = w_in_xfer && (r_idx == 5'(IN_BYTES - 1));
    assign busy      = !((r_state == LOAD) && (r_idx == 5'd0));

    // A timeout shorter than one cycle has no meaning; nothing is built for it.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_invalid
    end

`ifdef MATMUL_SEQ_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_error;

    assign w_tmo_expired = (r_state == RUN) && !mm_done &&
                           (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYCLES - 1));
    assign error = r_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
            r_error   <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == RUN) ? r_tmo_cnt + c_tmo_w'(1) : '0;
            if (w_tmo_expired) r_error <= 1'b1;
        end
    end
`else
    assign w_tmo_expired = 1'b0;
    assign error         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mm_enable = 1'b0;
        w_capture = 1'b0;
        w_drain   = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                if (w_last_in) w_next = RUN;
            end
            RUN: begin
                mm_enable = 1'b1;
                if (mm_done)            w_next = CAPTURE;
                else if (w_tmo_expired) w_next = LOAD;
            end
            CAPTURE: begin
                mm_enable = 1'b1;
                w_capture = 1'b1;
                w_next    = DRAIN;
            end
            DRAIN: begin
                w_drain = 1'b1;
                if (w_last_out) w_next = LOAD;
            end
            default: w_next = LOAD;
        endcase
    end

    // Operand slots: index 0..8 fill A, 9..17 fill B.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ELEM; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
            r_idx <= '0;
        end else if (w_in_xfer) begin
            for (int i = 0; i < N_ELEM; i++) begin
                if (r_idx == 5'(i))          r_a[i] <= in_data;
                if (r_idx == 5'(i + N_ELEM)) r_b[i] <= in_data;
            end
            r_idx <= w_last_in ? 5'd0 : r_idx + 5'd1;
        end
    end

    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_pack
        assign mm_a[gi*OPW +: OPW] = r_a[gi];
        assign mm_b[gi*OPW +: OPW] = r_b[gi];
    end

    matmul_byte_serializer u_serializer (
        .clk         (clk),
        .reset       (reset),
        .i_capture   (w_capture),
        .i_drain     (w_drain),
        .i_result    (mm_c),
        .i_out_ready (out_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_last_xfer (w_last_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
//============================================================================
// Module : tb_matmul_sequencer
// Brief  : Directed scoreboard bench for matmul_sequencer with a 3-cycle
//          engine model.
// Rev    : 1.0
//============================================================================
`default_nettype none

module tb_matmul_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_ready;
    logic         busy;
    logic [71:0]  mm_a;
    logic [71:0]  mm_b;
    logic         mm_enable;
    logic [161:0] mm_c;
    logic         mm_done;
    logic         error;

    int           total = 0;
    int           bad   = 0;
    logic [7:0]   sb [$];
    logic [7:0]   op_a [9];
    logic [7:0]   op_b [9];

    logic [1:0]   eng_cnt;
    logic         eng_done;
    logic         kill_done;

    matmul_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_enable (mm_enable),
        .mm_c      (mm_c),
        .mm_done   (mm_done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Engine model: done 3 cycles after enable rises, held while enabled.
    always_ff @(posedge clk) begin
        if (!mm_enable) begin
            eng_cnt  <= 2'd0;
            eng_done <= 1'b0;
        end else if (eng_cnt == 2'd2) begin
            eng_done <= 1'b1;
        end else begin
            eng_cnt <= eng_cnt + 2'd1;
        end
    end
    assign mm_done = eng_done & ~kill_done;

    always_comb begin
        mm_c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                logic [17:0] acc;
                acc = '0;
                for (int k = 0; k < 3; k++)
                    acc = acc + 18'(mm_a[(i*3+k)*8 +: 8]) * 18'(mm_b[(k*3+j)*8 +: 8]);
                mm_c[(i*3+j)*18 +: 18] = acc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] pack(input logic [7:0] v [9]);
        logic [71:0] p;
        for (int i = 0; i < 9; i++) p[i*8 +: 8] = v[i];
        return p;
    endfunction

    task automatic push_expected();
        for (int e = 0; e < 9; e++) begin
            int acc;
            acc = 0;
            for (int k = 0; k < 3; k++)
                acc += int'(op_a[(e/3)*3+k]) * int'(op_b[k*3+(e%3)]);
            sb.push_back(acc[7:0]);
            sb.push_back(acc[15:8]);
            sb.push_back({6'b0, acc[17:16]});
        end
    endtask

    task automatic load_ops(input int stall_at, input int stall_len, input bit expect_out);
        for (int i = 0; i < 18; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk); @(negedge clk);
                    chk("stall_in_ready", in_ready, 1);
                    chk("stall_busy", busy, 1);
                end
            end
            in_valid = 1'b1;
            if (i < 9) in_data = op_a[i];
            else       in_data = op_b[i-9];
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (expect_out) push_expected();
    endtask

    task automatic wait_output(input int exp_lat);
        int lat;
        lat = 1;
        chk("run_mm_enable", mm_enable, 1);
        chk("run_in_ready", in_ready, 0);
        chk("run_busy", busy, 1);
        chk("run_mm_a", mm_a, pack(op_a));
        chk("run_mm_b", mm_b, pack(op_b));
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("drain_mm_enable", mm_enable, 0);
    endtask

    task automatic drain(input int n, input logic [3:0] pat);
        int         got;
        int         cyc;
        logic       stalled;
        logic [7:0] held;
        logic [7:0] exp;
        got = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
        while (got < n && cyc < 200) begin
            out_ready = pat[cyc % 4];
            chk("out_valid", out_valid, 1);
            if (stalled) chk("stall_stable", out_data, held);
            if (out_ready) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hEE;
                chk("out_data", out_data, exp);
                got++;
                stalled = 1'b0;
            end else begin
                held    = out_data;
                stalled = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        chk("drain_count", got, n);
    endtask

    task automatic check_idle();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_mm_enable", mm_enable, 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic random_ops();
        for (int i = 0; i < 9; i++) begin
            op_a[i] = 8'($urandom_range(0, 255));
            op_b[i] = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        kill_done = 1'b0;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mm_enable", mm_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_mm_b", mm_b, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Identity times 1..9 with the consumer always ready.
        for (int i = 0; i < 9; i++) begin
            op_a[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
            op_b[i] = 8'(i + 1);
        end
        load_ops(-1, 0, 1'b1);
        wait_output(6);
        drain(27, 4'b1111);
        check_idle();

        // Saturated operands give 195075 per element.
        for (int i = 0; i < 9; i++) begin
            op_a[i] = 8'd255;
            op_b[i] = 8'd255;
        end
        load_ops(-1, 0, 1'b1);
        wait_output(6);
        drain(27, 4'b1111);
        check_idle();

        // Consumer stalls with ready pattern 1,0,0,1.
        random_ops();
        load_ops(-1, 0, 1'b1);
        wait_output(6);
        drain(27, 4'b1001);
        check_idle();

        // Same operands, unstalled then with a 5-cycle input gap before byte 9.
        random_ops();
        load_ops(-1, 0, 1'b1);
        wait_output(6);
        drain(27, 4'b1111);
        check_idle();
        load_ops(9, 5, 1'b1);
        wait_output(6);
        drain(27, 4'b1111);
        check_idle();

        // Reset lands while byte 13 of the drain is on offer.
        random_ops();
        load_ops(-1, 0, 1'b1);
        wait_output(6);
        drain(12, 4'b1111);
        chk("pre_rst_out_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_mm_enable", mm_enable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_mm_a", mm_a, 0);
        sb.delete();
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        random_ops();
        load_ops(-1, 0, 1'b1);
        wait_output(6);
        drain(27, 4'b1111);
        check_idle();

`ifdef MATMUL_SEQ_TIMEOUT_EN
        // Engine never answers: expect a timeout 8 cycles into RUN.
        kill_done = 1'b1;
        random_ops();
        load_ops(-1, 0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            chk("tmo_error_low", error, 0);
            chk("tmo_enable_high", mm_enable, 1);
            @(negedge clk);
        end
        chk("tmo_error", error, 1);
        chk("tmo_mm_enable", mm_enable, 0);
        chk("tmo_in_ready", in_ready, 1);
        for (int k = 0; k < 10; k++) begin
            chk("tmo_no_out_valid", out_valid, 0);
            @(negedge clk);
        end
        chk("tmo_sticky", error, 1);
        kill_done = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("tmo_cleared", error, 0);
        @(negedge clk);
`else
        chk("no_timeout_error", error, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
